// File: rtl/mux4in1_serializer.sv
// -----------------------------------------------------------------------------
// mux4in1_serializer
//   Accepts a bundle of four N-bit lanes in one cycle and emits the words one
//   per cycle on a single N-bit stream, tagged with their lane index.
//   Emission order is 0,1,2,3 (BITREV=0) or 0,2,1,3 (BITREV=1, 2-bit
//   bit-reversed order for FFT output reordering). A new bundle can be
//   accepted on the same cycle the last word transfers, so back-to-back
//   bundles stream without a bubble.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in0..in3   lane data, sampled only when in_valid & in_ready
//   in_valid   bundle on in0..in3 is valid
//   in_ready   bundle accepted this cycle (combinational from out_ready)
//   out        serialized word (registered)
//   out_sel    lane index of out (registered)
//   out_valid  out/out_sel/out_last valid (registered)
//   out_last   out is the 4th word of its bundle (registered)
//   out_ready  downstream accepts the current word
// -----------------------------------------------------------------------------
module mux4in1_serializer #(
  parameter int N      = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic [1:0]   out_sel,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [N-1:0] bundle_q [4];
  logic [N-1:0] bundle_d [4];
  logic [N-1:0] out_q, out_d;
  logic [1:0]   sel_q, sel_d;
  logic         last_q, last_d;
  logic [1:0]   lane_d;
  logic         accept;
  logic         xfer;

  // Map emission position to lane index.
  function automatic logic [1:0] lane_of(input logic [1:0] pos);
    if (BITREV) begin
      return {pos[0], pos[1]};
    end else begin
      return pos;
    end
  endfunction

  // Handshake decode; a reload is only possible as the last word leaves.
  always_comb begin
    in_ready = (state_q == ST_IDLE) ||
               ((state_q == ST_SEND) && (cnt_q == 2'd3) && out_ready);
    accept   = in_valid && in_ready;
    xfer     = (state_q == ST_SEND) && out_ready;
  end

  // Next-state for FSM, position counter and bundle buffer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bundle_d = bundle_q;
    if (xfer && (cnt_q != 2'd3)) begin
      cnt_d = cnt_q + 2'd1;
    end else if (accept) begin
      bundle_d[0] = in0;
      bundle_d[1] = in1;
      bundle_d[2] = in2;
      bundle_d[3] = in3;
      cnt_d       = 2'd0;
      state_d     = ST_SEND;
    end else if (xfer) begin
      // Last word left and nothing waiting: fall back to idle.
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Output word is selected from the next-state buffer/counter so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    lane_d = lane_of(cnt_d);
    out_d  = out_q;
    sel_d  = sel_q;
    last_d = (state_d == ST_SEND) && (cnt_d == 2'd3);
    if (state_d == ST_SEND) begin
      out_d = bundle_d[lane_d];
      sel_d = lane_d;
    end else begin
      out_d = out_q;
      sel_d = sel_q;
    end
  end

  // State, buffer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      bundle_q[0] <= '0;
      bundle_q[1] <= '0;
      bundle_q[2] <= '0;
      bundle_q[3] <= '0;
      out_q       <= '0;
      sel_q       <= 2'd0;
      last_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bundle_q <= bundle_d;
      out_q    <= out_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = sel_q;
  assign out_last  = last_q;
  assign out_valid = (state_q == ST_SEND);

endmodule

// File: doc/mux4in1_serializer.md
Name: mux4in1_serializer

Overview:
- Gathers four N-bit lanes presented in parallel and emits them one word per cycle on a single N-bit stream, with the lane index alongside.
- Inverse of the 1-to-4 lane demultiplexer: it recombines radix-4 butterfly outputs, or four demuxed sample lanes, into one serial sample stream.
- Supports natural lane order or 2-bit bit-reversed lane order for FFT output reordering.
- Valid/ready handshakes on both sides; full throughput of one word per cycle with back-to-back bundles.

Parameters:
- N, 16, width of each lane and of the output word.
- BITREV, 0, lane emission order: 0 emits lanes 0,1,2,3; 1 emits lanes 0,2,1,3.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in0  input  N  lane 0 data.
- in1  input  N  lane 1 data.
- in2  input  N  lane 2 data.
- in3  input  N  lane 3 data.
- in_valid  input  1  in0..in3 hold a valid bundle.
- in_ready  output  1  block accepts a bundle this cycle.
- out  output  N  serialized word, registered.
- out_sel  output  2  lane index of the current out word.
- out_valid  output  1  out and out_sel are valid.
- out_last  output  1  current word is the 4th of its bundle.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset: while rst=1 at a clock edge, the block returns to IDLE, clears the bundle buffer and the counter, and drives out=0, out_sel=0, out_valid=0, out_last=0.
- Reset mid-bundle: remaining words of the bundle are discarded. The first cycle after reset is IDLE with in_ready=1.
- Bundle buffer: four N-bit registers plus a 2-bit position counter cnt (0..3).
- State IDLE:
  - out_valid=0, in_ready=1.
  - On in_valid=1: capture in0..in3, set cnt=0 and go to SEND.
  - The first word appears on out on the next cycle, so input-to-output latency is 1 cycle.
- State SEND:
  - out_valid=1.
  - out = buffer[lane(cnt)], out_sel = lane(cnt), out_last = (cnt==3).
  - lane(cnt) = cnt when BITREV=0; lane(cnt) = {cnt[0],cnt[1]} when BITREV=1.
  - Transfer occurs when out_valid & out_ready.
  - On a transfer with cnt<3: cnt increments.
  - On a transfer with cnt==3 and in_valid=1: load the new bundle, cnt=0, stay in SEND. There is no bubble.
  - On a transfer with cnt==3 and in_valid=0: go to IDLE, out_valid=0 next cycle.
- in_ready = IDLE, or (SEND & cnt==3 & out_ready). It is combinational from out_ready; no other combinational paths exist.
- Stall: while out_ready=0, out, out_sel, out_last and out_valid hold stable, and in_ready=0 (except in IDLE).
- Buffer stability: in0..in3 are sampled only on the accepting cycle (in_valid & in_ready). Input changes at any other time have no effect.
- No arithmetic is performed on data; words pass bit-exact.
- cnt wraps 3 -> 0 only on a bundle reload. It never wraps without a new bundle.

Test Plan:
- Reset and idle: hold rst=1 for 2 cycles, then release. Require out_valid=0, in_ready=1, out=0. Then drive in0..3 = 16'h0011/16'h0022/16'h0033/16'h0044 with in_valid=1 for one cycle and out_ready=1. Require out = 0011,0022,0033,0044 on the 4 following cycles, out_sel = 0,1,2,3, out_last only on 0044, then out_valid=0.
- Bit-reverse: with BITREV=1 and the same bundle, require out = 0011,0033,0022,0044 with out_sel = 0,2,1,3.
- Back-to-back: keep in_valid=1 with bundles A (1..4) and B (5..8) and out_ready=1. Require 8 consecutive valid words 1..8 with no gap, and in_ready=1 only in the idle cycle and on the word-4 cycle.
- Backpressure: deassert out_ready for 3 cycles while word 2 is presented. Require out=word2, out_sel=1 and out_valid=1 held for all 3 cycles, in_ready=0, and no word lost or duplicated after out_ready=1 returns.
- Input ignored when busy: change in0..3 to FFFF while in SEND with cnt<3. Require the output sequence to still carry the originally captured bundle.
- Mid-bundle reset: assert rst for one cycle after word 2 transfers. Require the next cycle to show out_valid=0 and in_ready=1, and a fresh bundle 9..C to emit 9,A,B,C from out_sel=0.
